data_mem: RTL

Data-memory responder for the 8-bit micro's data bus: the target side of the instruction cycle's `mem_addr` / `mem_data` / `mem_WE` interface.

- Holds a `2**MEM_ADDR_WIDTH`-entry synchronous RAM with registered reads.
- After every reset, sweeps the whole array to zero and only then raises `mem_ready`.
- Optionally maps two addresses onto an output port and a synchronized input port.
- Sits beside the CPU core in the top level; its read data feeds the core's `mem_data_i`.

---
 rtl/data_mem_if.sv | 21 ++
 rtl/data_mem.sv | 120 ++++++++++++
 2 files changed

// File: rtl/data_mem_if.sv
// rtl/data_mem_if.sv - data bus between the 8-bit core and the data memory
interface data_mem_if #(
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int MEM_DATA_WIDTH = 8
);
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [MEM_DATA_WIDTH-1:0] mem_data_i;
  logic                      mem_WE;
  logic [MEM_DATA_WIDTH-1:0] mem_data_o;
  logic                      mem_ready;

  modport master (
    output mem_addr, mem_data_i, mem_WE,
    input  mem_data_o, mem_ready
  );

  modport slave (
    input  mem_addr, mem_data_i, mem_WE,
    output mem_data_o, mem_ready
  );
endinterface

// File: rtl/data_mem.sv
// rtl/data_mem.sv - data memory with clear-on-reset sweep and registered reads
// Optional I/O map of the two top addresses: define DATA_MEM_IO_EN.
module data_mem #(
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int MEM_DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      arst,
  data_mem_if.slave                 bus,
  input  logic [MEM_DATA_WIDTH-1:0] io_in,
  output logic [MEM_DATA_WIDTH-1:0] io_out
);
  localparam int DEPTH = 2 ** MEM_ADDR_WIDTH;
  localparam logic [MEM_ADDR_WIDTH-1:0] TOP = '1;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t                    state, state_nxt;
  logic [MEM_ADDR_WIDTH-1:0] clr_addr, clr_addr_nxt;
  logic                      ready_q, ready_nxt;
  logic [MEM_DATA_WIDTH-1:0] data_o_q, data_o_nxt;

  logic                      ram_we;
  logic [MEM_ADDR_WIDTH-1:0] ram_wa;
  logic [MEM_DATA_WIDTH-1:0] ram_wd;
  logic [MEM_DATA_WIDTH-1:0] ram_rd;
  logic [MEM_DATA_WIDTH-1:0] rd_data;
  logic                      io_hit_out, io_hit_in;

  logic [MEM_DATA_WIDTH-1:0] ram [0:DEPTH-1];

  assign ram_rd         = ram[bus.mem_addr];
  assign bus.mem_data_o = data_o_q;
  assign bus.mem_ready  = ready_q;

`ifdef DATA_MEM_IO_EN
  localparam logic [MEM_ADDR_WIDTH-1:0] IO_OUT_ADDR = TOP;
  localparam logic [MEM_ADDR_WIDTH-1:0] IO_IN_ADDR  = TOP - 1'b1;

  logic [MEM_DATA_WIDTH-1:0] io_sync1, io_sync2;
  logic                      io_out_we;

  assign io_hit_out = (bus.mem_addr == IO_OUT_ADDR);
  assign io_hit_in  = (bus.mem_addr == IO_IN_ADDR);
  assign io_out_we  = (state == ST_IDLE) && bus.mem_WE && io_hit_out;

  always_ff @(posedge clk) begin
    if (arst) begin
      io_sync1 <= '0;
      io_sync2 <= '0;
      io_out   <= '0;
    end else begin
      io_sync1 <= io_in;
      io_sync2 <= io_sync1;
      if (io_out_we) io_out <= bus.mem_data_i;
    end
  end

  // io_out read returns the pre-write value on a same-cycle write
  always_comb begin
    rd_data = ram_rd;
    if (io_hit_out)     rd_data = io_out;
    else if (io_hit_in) rd_data = io_sync2;
  end
`else
  logic unused_io_in;

  assign unused_io_in = ^io_in;
  assign io_hit_out   = 1'b0;
  assign io_hit_in    = 1'b0;
  assign io_out       = '0;
  assign rd_data      = ram_rd;
`endif

  always_ff @(posedge clk) begin
    if (arst) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
      ready_q  <= 1'b0;
      data_o_q <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
      ready_q  <= ready_nxt;
      data_o_q <= data_o_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    ready_nxt    = ready_q;
    data_o_nxt   = '0;
    ram_we       = 1'b0;
    ram_wa       = bus.mem_addr;
    ram_wd       = bus.mem_data_i;
    case (state)
      ST_CLEAR: begin
        ram_we       = 1'b1;
        ram_wa       = clr_addr;
        ram_wd       = '0;
        clr_addr_nxt = clr_addr + 1'b1;
        if (clr_addr == TOP) begin
          state_nxt = ST_IDLE;
          ready_nxt = 1'b1;
        end
      end
      ST_IDLE: begin
        data_o_nxt = rd_data;
        ram_we     = bus.mem_WE && !io_hit_out && !io_hit_in;
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  // Array has no reset; the sweep restores zeros after every reset
  always_ff @(posedge clk) begin
    if (ram_we && !arst) ram[ram_wa] <= ram_wd;
  end
endmodule
